// File: rtl/niosii_system_sysid_checker_pkg.sv
// rtl/niosii_system_sysid_checker_pkg.sv - shared types and constants for the sysid checker
package niosii_system_sysid_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID_REQ,
    ST_ID_WAIT,
    ST_TS_REQ,
    ST_TS_WAIT,
    ST_DONE
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1427411944;

endpackage

// File: rtl/niosii_system_sysid_checker_timer.sv
// rtl/niosii_system_sysid_checker_timer.sv - per-transaction watchdog counter (used under SYSID_CHECKER_TIMEOUT_EN)
module niosii_system_sysid_checker_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Count cycles spent in a request/wait state; expiry marks the last allowed cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_count == LAST_COUNT);

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// rtl/niosii_system_sysid_checker.sv - Avalon-MM sysid reader with pass/fail verdict; optional watchdog via SYSID_CHECKER_TIMEOUT_EN
module niosii_system_sysid_checker
  import niosii_system_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int          TIMEOUT_CYCLES     = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  state_e      r_state;
  state_e      w_state_next;
  logic        w_start_acc;
  logic        w_cap_id;
  logic        w_cap_ts;
  logic        w_to_done;
  logic        w_timed_out;
  logic        w_expired;
  logic [31:0] w_ts_final;

  logic        r_pass;
  logic        r_id_mm;
  logic        r_ts_mm;
  logic        r_timeout;
  logic [31:0] r_captured_id;
  logic [31:0] r_captured_ts;

`ifdef SYSID_CHECKER_TIMEOUT_EN
  logic w_timer_load;
  logic w_timer_en;

  assign w_timer_en = (r_state == ST_ID_REQ) || (r_state == ST_ID_WAIT) ||
                      (r_state == ST_TS_REQ) || (r_state == ST_TS_WAIT);
  assign w_timer_load = ((w_state_next == ST_ID_REQ) && (r_state != ST_ID_REQ)) ||
                        ((w_state_next == ST_TS_REQ) && (r_state != ST_TS_REQ));

  niosii_system_sysid_checker_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_load    (w_timer_load),
    .i_enable  (w_timer_en),
    .o_expired (w_expired)
  );
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
  assign w_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus the capture/finish strobes; acceptance or capture wins over a same-cycle expiry.
  always_comb begin
    w_state_next = r_state;
    w_start_acc  = 1'b0;
    w_cap_id     = 1'b0;
    w_cap_ts     = 1'b0;
    w_to_done    = 1'b0;
    w_timed_out  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_acc  = 1'b1;
          w_state_next = ST_ID_REQ;
        end
      end
      ST_ID_REQ, ST_TS_REQ: begin
        if (!avm_waitrequest) begin
          w_state_next = (r_state == ST_ID_REQ) ? ST_ID_WAIT : ST_TS_WAIT;
        end else if (w_expired) begin
          w_state_next = ST_DONE;
          w_to_done    = 1'b1;
          w_timed_out  = 1'b1;
        end
      end
      ST_ID_WAIT: begin
        if (avm_readdatavalid) begin
          w_cap_id     = 1'b1;
          w_state_next = ST_TS_REQ;
        end else if (w_expired) begin
          w_state_next = ST_DONE;
          w_to_done    = 1'b1;
          w_timed_out  = 1'b1;
        end
      end
      ST_TS_WAIT: begin
        if (avm_readdatavalid) begin
          w_cap_ts     = 1'b1;
          w_state_next = ST_DONE;
          w_to_done    = 1'b1;
        end else if (w_expired) begin
          w_state_next = ST_DONE;
          w_to_done    = 1'b1;
          w_timed_out  = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // The timestamp compare must see the word being captured this cycle, not the stale register.
  assign w_ts_final = w_cap_ts ? avm_readdata : r_captured_ts;

  // Capture registers and verdict flags; flags clear on an accepted start and settle on entry to DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_captured_id <= '0;
      r_captured_ts <= '0;
      r_pass        <= 1'b0;
      r_id_mm       <= 1'b0;
      r_ts_mm       <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_pass    <= 1'b0;
        r_id_mm   <= 1'b0;
        r_ts_mm   <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_cap_id) begin
        r_captured_id <= avm_readdata;
      end
      if (w_cap_ts) begin
        r_captured_ts <= avm_readdata;
      end
      if (w_to_done) begin
        r_id_mm   <= (r_captured_id != EXPECTED_ID);
        r_ts_mm   <= (w_ts_final != EXPECTED_TIMESTAMP);
        r_timeout <= w_timed_out;
        r_pass    <= (r_captured_id == EXPECTED_ID) && (w_ts_final == EXPECTED_TIMESTAMP) &&
                     !w_timed_out;
      end
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign avm_read    = (r_state == ST_ID_REQ) || (r_state == ST_TS_REQ);
  assign avm_address = ((r_state == ST_TS_REQ) || (r_state == ST_TS_WAIT)) ? SYSID_ADDR_TS
                                                                           : SYSID_ADDR_ID;
  assign pass        = r_pass;
  assign id_mismatch = r_id_mm;
  assign ts_mismatch = r_ts_mm;
  assign timeout     = r_timeout;
  assign captured_id = r_captured_id;
  assign captured_ts = r_captured_ts;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// tb/tb_niosii_system_sysid_checker.sv - scoreboard bench for the sysid checker (timeout case under SYSID_CHECKER_TIMEOUT_EN)
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] GOOD_TS = 32'h551493E8;

  logic        clock;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy;
  logic        done;
  logic        pass;
  logic        id_mismatch;
  logic        ts_mismatch;
  logic        timeout;
  logic [31:0] captured_id;
  logic [31:0] captured_ts;

  niosii_system_sysid_checker #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .id_mismatch       (id_mismatch),
    .ts_mismatch       (ts_mismatch),
    .timeout           (timeout),
    .captured_id       (captured_id),
    .captured_ts       (captured_ts)
  );

  typedef struct {
    int          start_cyc;
    int          lat;
    logic        p;
    logic        idm;
    logic        tsm;
    logic        to;
    logic [31:0] cid;
    logic [31:0] cts;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] sl_id = 32'd0;
  logic [31:0] sl_ts = GOOD_TS;
  int          sl_ws = 0;
  int          sl_delay = 0;
  bit          sl_drop = 1'b0;
  bit          inj_rdv = 1'b0;
  logic [31:0] inj_data = 32'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Avalon slave model: optional waitrequest cycles, configurable response delay, injectable spurious valid.
  initial begin
    int          ws_cnt = 0;
    logic        ws_addr = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'd0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'd0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'd0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = pend_data;
        end
      end
      if (inj_rdv) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = inj_data;
        inj_rdv           = 1'b0;
      end
      avm_waitrequest = 1'b0;
      if (ws_cnt > 0) begin
        chk("wait_hold_read", {31'd0, avm_read}, 32'd1);
        chk("wait_hold_addr", {31'd0, avm_address}, {31'd0, ws_addr});
      end
      if (avm_read) begin
        if (ws_cnt < sl_ws) begin
          avm_waitrequest = 1'b1;
          if (ws_cnt == 0) ws_addr = avm_address;
          ws_cnt++;
        end else begin
          ws_cnt = 0;
          if (!sl_drop) begin
            pend_cnt  = 1 + sl_delay;
            pend_data = avm_address ? sl_ts : sl_id;
          end
        end
      end else begin
        ws_cnt = 0;
      end
    end
  end

  // Monitor: every done pulse is matched against the oldest queued expectation.
  initial forever begin
    @(negedge clock);
    if (!reset && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
        chk("pass", {31'd0, pass}, {31'd0, e.p});
        chk("id_mismatch", {31'd0, id_mismatch}, {31'd0, e.idm});
        chk("ts_mismatch", {31'd0, ts_mismatch}, {31'd0, e.tsm});
        chk("timeout", {31'd0, timeout}, {31'd0, e.to});
        chk("captured_id", captured_id, e.cid);
        chk("captured_ts", captured_ts, e.cts);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "time limit");
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clock);
    while (busy === 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("idle_budget", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_for(input logic want_read, input logic want_addr, input int budget);
    int n = 0;
    while (!(busy === 1'b1 && avm_read === want_read && avm_address === want_addr) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("reach_state", {30'd0, busy, avm_read}, {30'd0, 1'b1, want_read});
  endtask

  task automatic push_exp(input int sc, input int lat, input logic p, input logic idm,
                          input logic tsm, input logic to, input logic [31:0] cid,
                          input logic [31:0] cts);
    exp_t e;
    e.start_cyc = sc; e.lat = lat; e.p = p; e.idm = idm; e.tsm = tsm; e.to = to;
    e.cid = cid; e.cts = cts;
    sb_q.push_back(e);
  endtask

  task automatic run_check(input logic [31:0] id, input logic [31:0] ts, input int ws,
                           input bit drop, input int lat, input logic p, input logic idm,
                           input logic tsm, input logic to, input logic [31:0] cid,
                           input logic [31:0] cts);
    sl_id = id; sl_ts = ts; sl_ws = ws; sl_delay = 0; sl_drop = drop;
    @(negedge clock);
    push_exp(cyc, lat, p, idm, tsm, to, cid, cts);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle(100);
    sl_ws = 0; sl_drop = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_avm_read", {31'd0, avm_read}, 32'd0);
    chk("rst_avm_address", {31'd0, avm_address}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_id_mismatch", {31'd0, id_mismatch}, 32'd0);
    chk("rst_ts_mismatch", {31'd0, ts_mismatch}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_captured_id", captured_id, 32'd0);
    chk("rst_captured_ts", captured_ts, 32'd0);
  endtask

  initial begin
    int c0;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clock);

    // Zero-wait, matching words: done in cycle 5.
    run_check(32'd0, GOOD_TS, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, GOOD_TS);

`ifdef SYSID_CHECKER_TIMEOUT_EN
    // ID read never answered: done 8 cycles after ID_REQ entry, old captures kept.
    run_check(32'd0, GOOD_TS, 0, 1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, GOOD_TS);
    inj_data = 32'h12345678;
    inj_rdv  = 1'b1;
    repeat (3) @(negedge clock);
    chk("late_rdv_id", captured_id, 32'd0);
    chk("late_rdv_ts", captured_ts, GOOD_TS);
    chk("late_rdv_busy", {31'd0, busy}, 32'd0);
`endif

    // Timestamp off by one; also proves a new start clears any earlier timeout.
    run_check(32'd0, 32'h551493E9, 0, 1'b0, 5, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h551493E9);
    // ID mismatch only.
    run_check(32'd1, GOOD_TS, 0, 1'b0, 5, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, GOOD_TS);
    // Three waitrequest cycles on each read: done in cycle 11.
    run_check(32'd0, GOOD_TS, 3, 1'b0, 11, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, GOOD_TS);

    // Start held high re-triggers the cycle after DONE.
    sl_id = 32'd0; sl_ts = GOOD_TS;
    @(negedge clock);
    c0 = cyc;
    push_exp(c0, 5, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, GOOD_TS);
    push_exp(c0 + 6, 5, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, GOOD_TS);
    start = 1'b1;
    repeat (7) @(negedge clock);
    start = 1'b0;
    wait_idle(100);

    // Spurious readdatavalid in IDLE is ignored.
    inj_data = 32'hDEADBEEF;
    inj_rdv  = 1'b1;
    repeat (3) @(negedge clock);
    chk("spurious_id", captured_id, 32'd0);
    chk("spurious_ts", captured_ts, GOOD_TS);
    chk("spurious_busy", {31'd0, busy}, 32'd0);

    // Start during ID_WAIT is ignored; reset in TS_WAIT aborts with no completion.
    sl_delay = 3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_for(1'b0, 1'b0, 20);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_ignored_read", {31'd0, avm_read}, 32'd0);
    chk("start_ignored_addr", {31'd0, avm_address}, 32'd0);
    wait_for(1'b0, 1'b1, 20);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs();
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_cap_id", captured_id, 32'd0);
    chk("post_reset_cap_ts", captured_ts, 32'd0);
    sl_delay = 0;

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
